// File: rtl/trace_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// trace_uart_tx_pkg : shared FSM encoding and UART frame constants
// Rev 1.0
// ============================================================================
package trace_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned C_DATA_BITS      = 8;
  localparam int unsigned C_DEF_CLK_FREQ   = 25_000_000;
  localparam int unsigned C_DEF_BAUD       = 115_200;

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// uart_byte_fifo : synchronous byte FIFO with full/empty flags and head output
// Rev 1.0
// ============================================================================
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Flags come from the registered count only, so a pop never frees room for a same-edge push.
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/trace_uart_tx.sv
`default_nettype none
// ============================================================================
// trace_uart_tx : FIFO-buffered 8N1 UART transmitter for the trace back end
// Rev 1.0
// ============================================================================
module trace_uart_tx
  import trace_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = C_DEF_CLK_FREQ,
  parameter int unsigned BAUD       = C_DEF_BAUD,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       TxD,
  output logic [7:0] txd_buffer,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned DIVISOR = CLK_FREQ / BAUD;
  localparam int unsigned BW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [BW-1:0] C_BAUD_LAST = BW'(DIVISOR - 1);
  localparam logic [2:0]    C_BIT_LAST  = 3'(C_DATA_BITS - 1);

  uart_state_t r_state, w_next_state;
  logic [BW-1:0] r_baud_cnt, w_baud_next;
  logic [2:0]    r_bit_cnt, w_bit_next;
  logic [7:0]    r_shift, w_shift_next;
  logic [7:0]    r_txd_buf, w_txd_buf_next;
  logic          r_txd, w_txd_next;
  logic          r_overflow;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic          w_baud_end;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign w_baud_end = (r_baud_cnt == C_BAUD_LAST);

  always_comb begin
    w_next_state   = r_state;
    w_baud_next    = r_baud_cnt;
    w_bit_next     = r_bit_cnt;
    w_shift_next   = r_shift;
    w_txd_buf_next = r_txd_buf;
    w_pop          = 1'b0;
    w_txd_next     = 1'b1;

    if (r_state != ST_IDLE) begin
      w_baud_next = w_baud_end ? '0 : r_baud_cnt + BW'(1);
    end

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_shift_next   = w_head;
          w_txd_buf_next = w_head;
          w_next_state   = ST_START;
        end
      end
      ST_START: begin
        if (w_baud_end) begin
          w_next_state = ST_DATA;
          w_bit_next   = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          if (r_bit_cnt == C_BIT_LAST) begin
            w_next_state = ST_STOP;
          end else begin
            w_shift_next = r_shift >> 1;
            w_bit_next   = r_bit_cnt + 3'd1;
          end
        end
      end
      ST_STOP: begin
        // Back-to-back frames: the next byte is loaded on the last stop-bit cycle.
        if (w_baud_end) begin
          if (!w_empty) begin
            w_pop          = 1'b1;
            w_shift_next   = w_head;
            w_txd_buf_next = w_head;
            w_next_state   = ST_START;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase

    // Line level is registered from the next state so TxD changes exactly on the bit boundary.
    case (w_next_state)
      ST_START: w_txd_next = 1'b0;
      ST_DATA:  w_txd_next = w_shift_next[0];
      default:  w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_txd_buf  <= '0;
      r_txd      <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_baud_cnt <= w_baud_next;
      r_bit_cnt  <= w_bit_next;
      r_shift    <= w_shift_next;
      r_txd_buf  <= w_txd_buf_next;
      r_txd      <= w_txd_next;
      if (in_valid && w_full) r_overflow <= 1'b1;
    end
  end

  assign in_ready   = !w_full;
  assign TxD        = r_txd;
  assign txd_buffer = r_txd_buf;
  assign busy       = (r_state != ST_IDLE) || !w_empty;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_trace_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_trace_uart_tx : directed self-checking bench, DIVISOR=8, FIFO_DEPTH=4
// Rev 1.0
// ============================================================================
module tb_trace_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       TxD;
  logic [7:0] txd_buffer;
  logic       busy;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  trace_uart_tx #(
    .CLK_FREQ   (8),
    .BAUD       (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .TxD        (TxD),
    .txd_buffer (txd_buffer),
    .busy       (busy),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  // Walks one frame cycle by cycle; skip = cycles of the start bit already elapsed.
  task automatic frame(input string tag, input logic [7:0] b, input int skip);
    for (int k = 0; k < 10; k++) begin
      logic e;
      int   bad;
      int   len;
      if (k == 0)      e = 1'b0;
      else if (k == 9) e = 1'b1;
      else             e = b[k-1];
      len = (k == 0) ? (8 - skip) : 8;
      bad = 0;
      for (int c = 0; c < len; c++) begin
        if (TxD !== e) bad++;
        tick();
      end
      check($sformatf("%s bit%0d", tag, k), 32'(bad), 32'd0);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      if (TxD !== 1'b1) bad++;
      tick();
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values, single byte 0xA5
    do_reset();
    check("rst TxD", 32'(TxD), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst txd_buffer", 32'(txd_buffer), 32'h00);
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1 TxD before pop", 32'(TxD), 32'd1);
    check("t1 busy queued", 32'(busy), 32'd1);
    tick();
    check("t1 txd_buffer", 32'(txd_buffer), 32'hA5);
    frame("t1 A5", 8'hA5, 0);
    check("t1 busy after frame", 32'(busy), 32'd0);
    check("t1 txd_buffer hold", 32'(txd_buffer), 32'hA5);

    // 2: back-to-back 0x55, 0x0F with no idle gap
    in_data  = 8'h55;
    in_valid = 1'b1;
    tick();
    in_data = 8'h0F;
    tick();
    in_valid = 1'b0;
    check("t2 txd_buffer 55", 32'(txd_buffer), 32'h55);
    frame("t2 55", 8'h55, 0);
    check("t2 txd_buffer 0F", 32'(txd_buffer), 32'h0F);
    frame("t2 0F", 8'h0F, 0);
    check("t2 busy end", 32'(busy), 32'd0);
    idle_check("t2 idle", 16);

    // 3: six-cycle burst, FIFO fills, sixth byte dropped
    for (int i = 0; i < 6; i++) begin
      in_data  = 8'(8'h10 + i);
      in_valid = 1'b1;
      tick();
      if (i == 4) begin
        check("t3 in_ready full", 32'(in_ready), 32'd0);
        check("t3 overflow before drop", 32'(overflow), 32'd0);
      end
    end
    in_valid = 1'b0;
    check("t3 overflow set", 32'(overflow), 32'd1);
    frame("t3 10", 8'h10, 4);
    frame("t3 11", 8'h11, 0);
    frame("t3 12", 8'h12, 0);
    frame("t3 13", 8'h13, 0);
    frame("t3 14", 8'h14, 0);
    idle_check("t3 no sixth frame", 24);
    check("t3 overflow sticky", 32'(overflow), 32'd1);
    check("t3 busy end", 32'(busy), 32'd0);

    // 4: reset during data bit 3 of 0xFF
    do_reset();
    check("t4 overflow cleared", 32'(overflow), 32'd0);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t4 start bit", 32'(TxD), 32'd0);
    repeat (35) tick();
    check("t4 busy mid frame", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t4 TxD on reset", 32'(TxD), 32'd1);
    check("t4 busy on reset", 32'(busy), 32'd0);
    check("t4 txd_buffer on reset", 32'(txd_buffer), 32'h00);
    check("t4 in_ready on reset", 32'(in_ready), 32'd1);
    reset = 1'b1;
    tick();
    idle_check("t4 no frame after release", 30);
    check("t4 busy after release", 32'(busy), 32'd0);

    // 5: pop at end of STOP with FIFO full and in_valid held
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h31;
    tick();
    in_data = 8'h32;
    tick();
    in_data = 8'h33;
    tick();
    in_data = 8'h34;
    tick();
    in_data = 8'h35;
    tick();
    check("t5 in_ready full", 32'(in_ready), 32'd0);
    in_data = 8'h36;
    frame("t5 31", 8'h31, 3);
    check("t5 in_ready after pop", 32'(in_ready), 32'd1);
    check("t5 txd_buffer 32", 32'(txd_buffer), 32'h32);
    check("t5 overflow", 32'(overflow), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t5 in_ready refilled", 32'(in_ready), 32'd0);
    frame("t5 32", 8'h32, 1);
    frame("t5 33", 8'h33, 0);
    frame("t5 34", 8'h34, 0);
    frame("t5 35", 8'h35, 0);
    frame("t5 36", 8'h36, 0);
    idle_check("t5 no extra frame", 24);
    check("t5 busy end", 32'(busy), 32'd0);

    // 6: all-zero and all-one bytes
    do_reset();
    in_data  = 8'h00;
    in_valid = 1'b1;
    tick();
    in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    frame("t6 00", 8'h00, 0);
    check("t6 txd_buffer FF", 32'(txd_buffer), 32'hFF);
    frame("t6 FF", 8'hFF, 0);
    idle_check("t6 idle", 16);
    check("t6 busy end", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
